// File: rtl/mem_responder.sv
// Memory responder: fixed-latency line-fill reads and single-word writes.
// One transaction in flight; y exposes the FSM state for the controller.
module mem_responder #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 3,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Mem_Req,
  input  logic              Mem_RW,
  input  logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_WData,
  output logic [DATA_W-1:0] Mem_RData,
  output logic              Mem_Valid,
  output logic              Data_ReadyM,
  output logic              Busy,
  output logic [2:0]        y
);

  localparam int BEAT_W = $clog2(LINE_WORDS);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] BURST = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [3:0]        cnt;
  logic [BEAT_W-1:0] beat;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] rd_addr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:  state_nx = Mem_Req ? WAIT : IDLE;
      WAIT: begin
        if (cnt != 4'd0) state_nx = WAIT;
        else if (rw_q)   state_nx = WRITE;
        else             state_nx = BURST;
      end
      BURST: begin
        if (beat == BEAT_W'(LINE_WORDS - 1)) state_nx = DONE;
        else                                 state_nx = BURST;
      end
      WRITE: state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      beat    <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Mem_Req) begin
            rw_q    <= Mem_RW;
            addr_q  <= Mem_Addr;
            wdata_q <= Mem_WData;
            cnt     <= 4'(LATENCY - 1);
            beat    <= '0;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        BURST: beat <= beat + 1'b1;
        default: ;
      endcase
    end
  end

  // The array has no reset; an aborting reset also blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && state == WRITE) mem[addr_q] <= wdata_q;
  end

  // Beat replaces only the low bits, so the top line never carries out.
  assign rd_addr = {addr_q[ADDR_W-1:BEAT_W], beat};

  always_comb begin
    Mem_Valid   = 1'b0;
    Mem_RData   = '0;
    Data_ReadyM = 1'b0;
    Busy        = (state != IDLE);
    y           = state;
    case (state)
      BURST: begin
        Mem_Valid = 1'b1;
        Mem_RData = mem[rd_addr];
      end
      DONE:  Data_ReadyM = 1'b1;
      default: ;
    endcase
  end

endmodule
